// File: rtl/regfile_write_scoreboard.sv
// rtl/regfile_write_scoreboard.sv - register write-enable decoder with pending-write scoreboard
module regfile_write_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_WPORTS = 2,
    parameter int SEL_W      = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WPORTS-1:0]        wb_en,
    input  logic [NUM_WPORTS*ADDR_W-1:0] wb_addr,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_addr,
    output logic                         issue_ready,
    output logic [NUM_REGS-1:0]          we_out,
    output logic [NUM_REGS*SEL_W-1:0]    wsel_out,
    output logic [NUM_REGS-1:0]          busy,
    output logic [ADDR_W:0]              pending_cnt,
    output logic                         collision,
    output logic                         err_stray_wb
);

    logic [NUM_REGS-1:0]       dec;
    logic [NUM_REGS*SEL_W-1:0] wsel_d;
    logic                      coll_d;
    logic                      stray_d;
    logic [NUM_REGS-1:0]       set_v;
    logic [NUM_REGS-1:0]       busy_d;
    logic [ADDR_W:0]           cnt_d;

    // Decode all writeback ports; first hit on a register claims wsel, any later hit is a collision
    always_comb begin
        dec    = '0;
        wsel_d = '0;
        coll_d = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int p = 0; p < NUM_WPORTS; p++) begin
                if (wb_en[p] && (wb_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) &&
                    !((ZERO_REG != 0) && (r == 0))) begin
                    if (dec[r]) begin
                        coll_d = 1'b1;
                    end else begin
                        dec[r]                    = 1'b1;
                        wsel_d[r*SEL_W +: SEL_W]  = SEL_W'(p);
                    end
                end
            end
        end
        stray_d = |(dec & ~busy);
    end

    // Issue is stalled while the destination is still pending; no bypass from this cycle's writeback
    always_comb begin
        issue_ready = !busy[issue_addr];
        set_v       = '0;
        if (issue_valid && issue_ready && !((ZERO_REG != 0) && (issue_addr == '0))) begin
            set_v[issue_addr] = 1'b1;
        end
    end

    // Next scoreboard state (a new claim beats a same-cycle clear) and its population count
    always_comb begin
        busy_d = (busy & ~dec) | set_v;
        cnt_d  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
        end
    end

    // Output and scoreboard registers; reset drops everything immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_out       <= '0;
            wsel_out     <= '0;
            busy         <= '0;
            pending_cnt  <= '0;
            collision    <= 1'b0;
            err_stray_wb <= 1'b0;
        end else begin
            we_out       <= dec;
            wsel_out     <= wsel_d;
            busy         <= busy_d;
            pending_cnt  <= cnt_d;
            collision    <= coll_d;
            err_stray_wb <= err_stray_wb | stray_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_scoreboard.sv
// tb/tb_regfile_write_scoreboard.sv - directed bench with behavioural scoreboard model
module tb_regfile_write_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  wb_en = 2'b00;
    logic [9:0]  wb_addr = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        issue_ready;
    logic [31:0] we_out;
    logic [31:0] wsel_out;
    logic [31:0] busy;
    logic [5:0]  pending_cnt;
    logic        collision;
    logic        err_stray_wb;

    int total = 0;
    int bad = 0;

    regfile_write_scoreboard dut (
        .clk(clk),
        .reset(reset),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .issue_valid(issue_valid),
        .issue_addr(issue_addr),
        .issue_ready(issue_ready),
        .we_out(we_out),
        .wsel_out(wsel_out),
        .busy(busy),
        .pending_cnt(pending_cnt),
        .collision(collision),
        .err_stray_wb(err_stray_wb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as bit arrays, ports processed one at a time
    bit       m_busy [32];
    bit       m_we   [32];
    bit       m_wsel [32];
    bit       m_coll;
    bit       m_err;

    function automatic bit [31:0] pack(input bit a [32]);
        bit [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < 32; i++) n += m_busy[i];
        return n;
    endfunction

    function automatic bit model_ready();
        return (issue_addr == 0) || !m_busy[issue_addr];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] <= 1'b0; m_we[i] <= 1'b0; m_wsel[i] <= 1'b0;
            end
            m_coll <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            automatic int  hits [32];
            automatic bit  nb   [32];
            automatic bit  nwe  [32];
            automatic bit  nsel [32];
            automatic bit  c = 1'b0;
            automatic bit  e = m_err;
            automatic bit  rdy = model_ready();
            for (int i = 0; i < 32; i++) begin
                hits[i] = 0; nb[i] = m_busy[i]; nwe[i] = 1'b0; nsel[i] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                automatic int a = int'(wb_addr[p*5 +: 5]);
                if (wb_en[p] && a != 0) begin
                    if (hits[a] == 0) nsel[a] = (p == 1);
                    hits[a]++;
                    nwe[a] = 1'b1;
                    if (!m_busy[a]) e = 1'b1;
                    nb[a] = 1'b0;
                end
            end
            for (int i = 0; i < 32; i++) if (hits[i] >= 2) c = 1'b1;
            if (issue_valid && rdy && issue_addr != 0) nb[issue_addr] = 1'b1;
            for (int i = 0; i < 32; i++) begin
                m_busy[i] <= nb[i]; m_we[i] <= nwe[i]; m_wsel[i] <= nsel[i];
            end
            m_coll <= c;
            m_err  <= e;
        end
    end

    // Compare every cycle outside reset, away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_we", we_out, pack(m_we));
            chk("m_wsel", wsel_out, pack(m_wsel));
            chk("m_busy", busy, pack(m_busy));
            chk("m_cnt", pending_cnt, count_busy());
            chk("m_coll", collision, m_coll);
            chk("m_err", err_stray_wb, m_err);
            chk("m_ready", issue_ready, model_ready());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wb_en = 2'b00; wb_addr = '0; issue_valid = 1'b0; issue_addr = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset with writes held on r3 (port0) and r7 (port1)
        reset = 1'b1;
        wb_en = 2'b11; wb_addr = {5'd7, 5'd3};
        #3;
        chk("rst_we", we_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", pending_cnt, 0);
        chk("rst_coll", collision, 0);
        chk("rst_err", err_stray_wb, 0);
        chk("rst_ready", issue_ready, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc();
        chk("rel_we", we_out, 32'h0000_0088);
        chk("rel_wsel", wsel_out, 32'h0000_0080);
        chk("rel_coll", collision, 0);
        chk("rel_err", err_stray_wb, 1);

        // Claim r5 then r9, then a write-after-write stall on r5
        idle();
        issue_valid = 1'b1; issue_addr = 5'd5;
        cyc();
        issue_addr = 5'd9;
        cyc();
        chk("claim_busy", busy, 32'h0000_0220);
        chk("claim_cnt", pending_cnt, 2);
        issue_addr = 5'd5;
        #1;
        chk("waw_ready", issue_ready, 0);
        cyc();
        chk("waw_busy", busy, 32'h0000_0220);
        idle();

        // Two ports collide on busy r12
        pulse_reset();
        issue_valid = 1'b1; issue_addr = 5'd12;
        cyc();
        idle();
        wb_en = 2'b11; wb_addr = {5'd12, 5'd12};
        cyc();
        chk("col_we", we_out, 32'h0000_1000);
        chk("col_wsel", wsel_out, 0);
        chk("col_coll", collision, 1);
        chk("col_busy", busy, 0);
        chk("col_err", err_stray_wb, 0);
        idle();
        cyc();
        chk("col_once", collision, 0);

        // Claim and stray writeback on r4 in the same cycle
        issue_valid = 1'b1; issue_addr = 5'd4;
        wb_en = 2'b01; wb_addr = {5'd0, 5'd4};
        cyc();
        chk("setclr_err", err_stray_wb, 1);
        chk("setclr_busy", busy, 32'h0000_0010);
        chk("setclr_we", we_out, 32'h0000_0010);
        idle();

        // Register 0 is inert
        pulse_reset();
        issue_valid = 1'b1; issue_addr = 5'd0;
        wb_en = 2'b11; wb_addr = {5'd0, 5'd0};
        #1;
        chk("r0_ready", issue_ready, 1);
        cyc();
        chk("r0_busy", busy, 0);
        chk("r0_we", we_out, 0);
        chk("r0_coll", collision, 0);
        chk("r0_err", err_stray_wb, 0);
        idle();

        // Claim every register, retire r31, then reset mid-cycle
        for (int a = 1; a < 32; a++) begin
            issue_valid = 1'b1; issue_addr = 5'(a);
            cyc();
        end
        chk("full_cnt", pending_cnt, 31);
        chk("full_busy", busy, 32'hFFFF_FFFE);
        idle();
        wb_en = 2'b01; wb_addr = {5'd0, 5'd31};
        cyc();
        chk("ret_we", we_out, 32'h8000_0000);
        chk("ret_cnt", pending_cnt, 30);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_cnt", pending_cnt, 0);
        chk("abort_we", we_out, 0);
        idle();
        cyc();
        reset = 1'b0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
